// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path: entry layout,
// controller states, trigger levels and the character-timeout multiplier.
package uart_pkg;

  localparam int DEPTH_DEF = 16;
  localparam int TO_MULT   = 64;
  localparam int TO_W      = 10;

  localparam logic [4:0] TRIG_T0 = 5'd1;
  localparam logic [4:0] TRIG_T1 = 5'd4;
  localparam logic [4:0] TRIG_T2 = 5'd8;
  localparam logic [4:0] TRIG_T3 = 5'd14;

  typedef struct packed {
    logic       bi;
    logic       fe;
    logic       pe;
    logic [7:0] data;
  } rx_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } rx_state_t;

  function automatic logic [4:0] trig_threshold(input logic [1:0] sel);
    logic [4:0] t;
    case (sel)
      2'b00:   t = TRIG_T0;
      2'b01:   t = TRIG_T1;
      2'b10:   t = TRIG_T2;
      default: t = TRIG_T3;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_ctrl_if.sv
// Receiver/host-side signal bundle of the receive FIFO controller.
interface uart_rx_fifo_ctrl_if #(parameter int DEPTH = 16);

  localparam int LW = $clog2(DEPTH) + 1;

  // push and pop are single-cycle strobes with no back-pressure: a push into a
  // full queue is dropped and reported through oe, a pop at empty is ignored.
  logic          push;
  logic [7:0]    din;
  logic          pe_in;
  logic          fe_in;
  logic          bi_in;
  logic          pop;
  logic          lsr_rd;
  logic [7:0]    dout;
  logic          pe;
  logic          fe;
  logic          bi;
  logic          dr;
  logic          oe;
  logic          rx_err;
  logic          rda_int;
  logic          cto_int;
  logic [LW-1:0] level;

  modport master (
    output push, din, pe_in, fe_in, bi_in, pop, lsr_rd,
    input  dout, pe, fe, bi, dr, oe, rx_err, rda_int, cto_int, level
  );

  modport slave (
    input  push, din, pe_in, fe_in, bi_in, pop, lsr_rd,
    output dout, pe, fe, bi, dr, oe, rx_err, rda_int, cto_int, level
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// Receive FIFO storage: DEPTH x 11-bit array, synchronous write, asynchronous read.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  rx_entry_t     wdata,
  input  logic [AW-1:0] raddr,
  output rx_entry_t     rdata
);

  rx_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// 16550-style receive FIFO controller: pointers, level, sticky overrun,
// error summary, trigger-level and character-timeout interrupts.
module uart_rx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int TRIG_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              baud_pulse,
  input  logic              fifo_en,
  input  logic              fifo_clr,
  input  logic [TRIG_W-1:0] trig_lvl,
  input  logic [1:0]        wls,
  input  logic              pen,
  input  logic              stb,
  uart_rx_fifo_ctrl_if.slave bus,
  output rx_state_t         state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  rx_state_t       state_q, next_state;
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [LW-1:0]   level_q, level_nxt, cap;
  logic [DEPTH-1:0] err_q;
  logic            fifo_en_q, oe_q, cto_q;
  logic [TO_W-1:0] cnt_q, cnt_nxt, to_thr;
  logic            empty_s, full_s, flush;
  logic            do_push, do_pop, overrun;
  logic            cnt_clr, cnt_inc, cto_set;
  rx_entry_t       wr_entry, head;

  // Toggling FIFO mode discards the queue exactly like an FCR1 flush.
  assign flush = fifo_clr | (fifo_en != fifo_en_q);
  assign cap   = fifo_en ? LW'(DEPTH) : LW'(1);

  // A pop frees the slot first, so a full queue still accepts a same-cycle push.
  assign do_pop  = bus.pop & ~empty_s & ~flush;
  assign do_push = bus.push & ~flush & (~full_s | do_pop);
  assign overrun = bus.push & ~flush & full_s & ~do_pop;

  assign wr_entry = rx_entry_t'({bus.bi_in, bus.fe_in, bus.pe_in, bus.din});

  uart_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (do_push),
    .waddr (wptr_q),
    .wdata (wr_entry),
    .raddr (rptr_q),
    .rdata (head)
  );

  always_comb begin
    level_nxt = level_q + LW'(do_push) - LW'(do_pop);
    if (flush) level_nxt = '0;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= next_state;
  end

  // Next-state: classification of the upcoming level against capacity
  always_comb begin
    next_state = ST_PARTIAL;
    if (level_nxt == '0)      next_state = ST_EMPTY;
    else if (level_nxt == cap) next_state = ST_FULL;
  end

  // Outputs
  always_comb begin
    empty_s     = (state_q == ST_EMPTY);
    full_s      = (state_q == ST_FULL);
    bus.dout    = empty_s ? 8'h00 : head.data;
    bus.pe      = ~empty_s & head.pe;
    bus.fe      = ~empty_s & head.fe;
    bus.bi      = ~empty_s & head.bi;
    bus.dr      = ~empty_s;
    bus.oe      = oe_q;
    bus.rx_err  = |err_q;
    bus.cto_int = cto_q;
    bus.level   = level_q;
    bus.rda_int = fifo_en ? (32'(level_q) >= 32'(trig_threshold(2'(trig_lvl)))) : ~empty_s;
    state_dbg   = state_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      fifo_en_q <= 1'b0;
    end else begin
      fifo_en_q <= fifo_en;
      level_q   <= level_nxt;
      if (flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (do_push) wptr_q <= wptr_q + AW'(1);
        if (do_pop)  rptr_q <= rptr_q + AW'(1);
      end
    end
  end

  // One error flag per slot; set after clear so a full push+pop on the same slot keeps the new flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else if (flush) begin
      err_q <= '0;
    end else begin
      if (do_pop)  err_q[rptr_q] <= 1'b0;
      if (do_push) err_q[wptr_q] <= bus.bi_in | bus.fe_in | bus.pe_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             oe_q <= 1'b0;
    else if (overrun)    oe_q <= 1'b1;
    else if (bus.lsr_rd) oe_q <= 1'b0;
  end

  // Four character times: 16 ticks/bit * 4 chars * (start + data + parity + stop bits).
  assign to_thr  = TO_W'(TO_MULT) * (TO_W'(7) + TO_W'(wls) + TO_W'(pen) + TO_W'(stb));
  assign cnt_clr = bus.push | bus.pop | flush | empty_s;
  assign cnt_inc = baud_pulse & fifo_en & ~empty_s & (cnt_q < to_thr);
  assign cnt_nxt = cnt_inc ? cnt_q + TO_W'(1) : cnt_q;
  assign cto_set = ~cnt_clr & fifo_en & (cnt_nxt >= to_thr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          cnt_q <= '0;
    else if (cnt_clr) cnt_q <= '0;
    else              cnt_q <= cnt_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           cto_q <= 1'b0;
    else if (bus.push | bus.pop | flush) cto_q <= 1'b0;
    else if (cto_set)                  cto_q <= 1'b1;
  end

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Scenario bench for uart_rx_fifo_ctrl: scoreboard of expected head entries
// plus a small level/overrun model kept by the bench.
module tb_uart_rx_fifo_ctrl;
  import uart_pkg::*;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_pulse, fifo_en, fifo_clr, pen, stb;
  logic [1:0] trig_lvl, wls;
  rx_state_t  state_dbg;

  uart_rx_fifo_ctrl_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_fifo_ctrl #(.DEPTH(DEPTH), .TRIG_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_pulse (baud_pulse),
    .fifo_en    (fifo_en),
    .fifo_clr   (fifo_clr),
    .trig_lvl   (trig_lvl),
    .wls        (wls),
    .pen        (pen),
    .stb        (stb),
    .bus        (bus),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  logic [10:0] exp_q[$];
  logic        model_oe;
  int          vectors, miscompares;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_cap();
    return fifo_en ? DEPTH : 1;
  endfunction

  task automatic push_word(input logic [10:0] e);
    bus.din = e[7:0]; bus.pe_in = e[8]; bus.fe_in = e[9]; bus.bi_in = e[10];
    bus.push = 1'b1;
    if (exp_q.size() < model_cap()) exp_q.push_back(e);
    else model_oe = 1'b1;
    step();
    bus.push = 1'b0;
  endtask

  task automatic pop_word(output logic [10:0] obs, output logic [10:0] exp_e);
    obs   = {bus.bi, bus.fe, bus.pe, bus.dout};
    exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h000;
    bus.pop = 1'b1;
    step();
    bus.pop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    vectors++; if ({bus.dout, bus.pe, bus.fe, bus.bi} !== 11'h000) begin miscompares++; $display("FAIL reset_head got %h want 000", {bus.dout, bus.pe, bus.fe, bus.bi}); end
    vectors++; if ({bus.dr, bus.oe, bus.rx_err, bus.rda_int, bus.cto_int} !== 5'b0) begin miscompares++; $display("FAIL reset_flags got %b want 00000", {bus.dr, bus.oe, bus.rx_err, bus.rda_int, bus.cto_int}); end
    vectors++; if (bus.level !== 5'd0) begin miscompares++; $display("FAIL reset_level got %0d want 0", bus.level); end
    rst = 1'b0;
    step(); step();
  endtask

  task automatic test_trigger();
    logic [10:0] obs, exp_e;
    fifo_en = 1'b1; trig_lvl = 2'b01;
    step(); step();
    push_word(11'h011); push_word(11'h022); push_word(11'h033);
    vectors++; if (bus.rda_int !== 1'b0) begin miscompares++; $display("FAIL trig_below got %b want 0", bus.rda_int); end
    push_word(11'h044);
    vectors++; if (bus.rda_int !== 1'b1) begin miscompares++; $display("FAIL trig_reach got %b want 1", bus.rda_int); end
    vectors++; if (bus.level !== 5'(exp_q.size())) begin miscompares++; $display("FAIL trig_level got %0d want %0d", bus.level, exp_q.size()); end
    pop_word(obs, exp_e);
    vectors++; if (obs !== exp_e) begin miscompares++; $display("FAIL trig_pop got %h want %h", obs, exp_e); end
    vectors++; if (bus.dout !== 8'h22) begin miscompares++; $display("FAIL trig_head got %h want 22", bus.dout); end
    vectors++; if (bus.rda_int !== 1'b0) begin miscompares++; $display("FAIL trig_drop got %b want 0", bus.rda_int); end
    while (exp_q.size() > 0) begin
      pop_word(obs, exp_e);
      vectors++; if (obs !== exp_e) begin miscompares++; $display("FAIL trig_drain got %h want %h", obs, exp_e); end
    end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < DEPTH + 1; i++) push_word({3'b000, 8'($urandom_range(0, 255))});
    vectors++; if (bus.level !== 5'(exp_q.size())) begin miscompares++; $display("FAIL ovr_level got %0d want %0d", bus.level, exp_q.size()); end
    vectors++; if (bus.oe !== model_oe) begin miscompares++; $display("FAIL ovr_oe got %b want %b", bus.oe, model_oe); end
    vectors++; if ({bus.bi, bus.fe, bus.pe, bus.dout} !== exp_q[0]) begin miscompares++; $display("FAIL ovr_head got %h want %h", {bus.bi, bus.fe, bus.pe, bus.dout}, exp_q[0]); end
    model_oe = 1'b0; bus.lsr_rd = 1'b1;
    push_word(11'h0EE);
    bus.lsr_rd = 1'b0;
    vectors++; if (bus.oe !== model_oe) begin miscompares++; $display("FAIL ovr_setwins got %b want %b", bus.oe, model_oe); end
    bus.lsr_rd = 1'b1; model_oe = 1'b0;
    step();
    bus.lsr_rd = 1'b0;
    vectors++; if (bus.oe !== model_oe) begin miscompares++; $display("FAIL ovr_lsrclr got %b want %b", bus.oe, model_oe); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] obs, exp_e;
    obs   = {bus.bi, bus.fe, bus.pe, bus.dout};
    exp_e = exp_q.pop_front();
    exp_q.push_back(11'h0C3);
    bus.din = 8'hC3; bus.pe_in = 1'b0; bus.fe_in = 1'b0; bus.bi_in = 1'b0;
    bus.push = 1'b1; bus.pop = 1'b1;
    step();
    bus.push = 1'b0; bus.pop = 1'b0;
    vectors++; if (obs !== exp_e) begin miscompares++; $display("FAIL b2b_pop got %h want %h", obs, exp_e); end
    vectors++; if (bus.oe !== model_oe) begin miscompares++; $display("FAIL b2b_oe got %b want %b", bus.oe, model_oe); end
    vectors++; if (bus.level !== 5'(exp_q.size())) begin miscompares++; $display("FAIL b2b_level got %0d want %0d", bus.level, exp_q.size()); end
    while (exp_q.size() > 0) begin
      pop_word(obs, exp_e);
      vectors++; if (obs !== exp_e) begin miscompares++; $display("FAIL b2b_drain got %h want %h", obs, exp_e); end
    end
    pop_word(obs, exp_e);
    vectors++; if (bus.level !== 5'd0 || bus.dr !== 1'b0) begin miscompares++; $display("FAIL b2b_emptypop got level %0d dr %b want 0 0", bus.level, bus.dr); end
  endtask

  task automatic test_timeout(input logic [1:0] w, input logic p, input logic s, input int ticks);
    logic [10:0] obs, exp_e;
    wls = w; pen = p; stb = s;
    push_word({3'b000, 8'($urandom_range(0, 255))});
    for (int i = 0; i < ticks - 1; i++) begin
      baud_pulse = 1'b1; step(); baud_pulse = 1'b0; step();
    end
    vectors++; if (bus.cto_int !== 1'b0) begin miscompares++; $display("FAIL cto_early ticks %0d got %b want 0", ticks, bus.cto_int); end
    baud_pulse = 1'b1; step(); baud_pulse = 1'b0; step();
    vectors++; if (bus.cto_int !== 1'b1) begin miscompares++; $display("FAIL cto_fire ticks %0d got %b want 1", ticks, bus.cto_int); end
    pop_word(obs, exp_e);
    vectors++; if (obs !== exp_e) begin miscompares++; $display("FAIL cto_pop got %h want %h", obs, exp_e); end
    vectors++; if (bus.cto_int !== 1'b0 || bus.dr !== 1'b0) begin miscompares++; $display("FAIL cto_clear got cto %b dr %b want 0 0", bus.cto_int, bus.dr); end
  endtask

  task automatic test_status_clr();
    logic [10:0] obs, exp_e;
    push_word({1'b0, 1'b1, 1'b0, 8'h3C});
    vectors++; if (bus.rx_err !== 1'b1 || bus.fe !== 1'b1) begin miscompares++; $display("FAIL err_set got rx_err %b fe %b want 1 1", bus.rx_err, bus.fe); end
    pop_word(obs, exp_e);
    vectors++; if (obs !== exp_e) begin miscompares++; $display("FAIL err_pop got %h want %h", obs, exp_e); end
    vectors++; if (bus.rx_err !== 1'b0) begin miscompares++; $display("FAIL err_clear got %b want 0", bus.rx_err); end
    for (int i = 0; i < DEPTH + 1; i++) push_word({1'b0, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255))});
    for (int i = 0; i < 3; i++) begin
      pop_word(obs, exp_e);
      vectors++; if (obs !== exp_e) begin miscompares++; $display("FAIL clr_pop got %h want %h", obs, exp_e); end
    end
    push_word({1'b1, 1'b0, 1'b0, 8'h77});
    fifo_clr = 1'b1; bus.push = 1'b1; bus.din = 8'h99;
    step();
    fifo_clr = 1'b0; bus.push = 1'b0;
    exp_q.delete();
    vectors++; if (bus.level !== 5'd0 || bus.dr !== 1'b0 || bus.dout !== 8'h00) begin miscompares++; $display("FAIL clr_level got level %0d dr %b dout %h want 0 0 00", bus.level, bus.dr, bus.dout); end
    vectors++; if (bus.oe !== model_oe) begin miscompares++; $display("FAIL clr_oe got %b want %b", bus.oe, model_oe); end
    vectors++; if (bus.rx_err !== 1'b0) begin miscompares++; $display("FAIL clr_rxerr got %b want 0", bus.rx_err); end
    bus.lsr_rd = 1'b1; model_oe = 1'b0; step(); bus.lsr_rd = 1'b0;
  endtask

  task automatic test_non_fifo();
    logic [10:0] obs, exp_e;
    fifo_en = 1'b0;
    step(); step();
    push_word(11'h0A5);
    push_word(11'h05A);
    vectors++; if (bus.dout !== 8'hA5 || bus.level !== 5'(exp_q.size())) begin miscompares++; $display("FAIL nf_head got %h level %0d want a5 %0d", bus.dout, bus.level, exp_q.size()); end
    vectors++; if (bus.oe !== model_oe || bus.rda_int !== 1'b1) begin miscompares++; $display("FAIL nf_flags got oe %b rda %b want %b 1", bus.oe, bus.rda_int, model_oe); end
    bus.lsr_rd = 1'b1; model_oe = 1'b0; step(); bus.lsr_rd = 1'b0;
    pop_word(obs, exp_e);
    vectors++; if (obs !== exp_e) begin miscompares++; $display("FAIL nf_pop got %h want %h", obs, exp_e); end
    vectors++; if (bus.dr !== 1'b0 || bus.rda_int !== 1'b0) begin miscompares++; $display("FAIL nf_empty got dr %b rda %b want 0 0", bus.dr, bus.rda_int); end
  endtask

  task automatic test_reset_mid();
    logic [10:0] obs, exp_e;
    fifo_en = 1'b1;
    step(); step();
    push_word(11'h101); push_word(11'h002); push_word(11'h003);
    #2 rst = 1'b1;
    #1;
    exp_q.delete(); model_oe = 1'b0;
    vectors++; if (bus.level !== 5'd0 || bus.dr !== 1'b0 || bus.dout !== 8'h00 || bus.rx_err !== 1'b0) begin miscompares++; $display("FAIL rstmid_async got level %0d dr %b dout %h rx_err %b want 0 0 00 0", bus.level, bus.dr, bus.dout, bus.rx_err); end
    step();
    rst = 1'b0;
    step(); step();
    push_word(11'h06B);
    vectors++; if (bus.level !== 5'(exp_q.size()) || bus.dout !== 8'h6B) begin miscompares++; $display("FAIL rstmid_push got level %0d dout %h want %0d 6b", bus.level, bus.dout, exp_q.size()); end
    pop_word(obs, exp_e);
    vectors++; if (obs !== exp_e) begin miscompares++; $display("FAIL rstmid_pop got %h want %h", obs, exp_e); end
  endtask

  initial begin
    vectors = 0; miscompares = 0; model_oe = 1'b0;
    rst = 1'b1; baud_pulse = 1'b0; fifo_en = 1'b0; fifo_clr = 1'b0;
    trig_lvl = 2'b00; wls = 2'b00; pen = 1'b0; stb = 1'b0;
    bus.push = 1'b0; bus.pop = 1'b0; bus.lsr_rd = 1'b0;
    bus.din = 8'h00; bus.pe_in = 1'b0; bus.fe_in = 1'b0; bus.bi_in = 1'b0;
    test_reset();
    test_trigger();
    test_overrun();
    test_back_to_back();
    test_timeout(2'b11, 1'b0, 1'b0, 640);
    test_timeout(2'b00, 1'b1, 1'b1, 576);
    test_status_clr();
    test_non_fifo();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
